// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle around sdram_port_arbiter: VGA line prefetcher, blitter and the SDRAM master port.
// The master modport is the arbiter's view; the slave modport is the view of everything around it.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_base;
    logic              vga_busy;
    logic [31:0]       vga_data;
    logic              vga_data_valid;
    logic              vga_done;

    logic              blit_read;
    logic              blit_write;
    logic [ADDR_W-1:0] blit_address;
    logic [31:0]       blit_wdata;
    logic [3:0]        blit_byteenable;
    logic [31:0]       blit_rdata;
    logic              blit_finished;

    logic              wait_req;
    logic              valid;
    logic [31:0]       data_from_mem;
    logic [ADDR_W-1:0] address_out;
    logic              read_out;
    logic              write_out;
    logic [3:0]        byte_enable;
    logic [31:0]       data_to_sdram;

    modport master (
        input  vga_req, vga_base,
        output vga_busy, vga_data, vga_data_valid, vga_done,
        input  blit_read, blit_write, blit_address, blit_wdata, blit_byteenable,
        output blit_rdata, blit_finished,
        input  wait_req, valid, data_from_mem,
        output address_out, read_out, write_out, byte_enable, data_to_sdram
    );

    modport slave (
        output vga_req, vga_base,
        input  vga_busy, vga_data, vga_data_valid, vga_done,
        output blit_read, blit_write, blit_address, blit_wdata, blit_byteenable,
        input  blit_rdata, blit_finished,
        output wait_req, valid, data_from_mem,
        input  address_out, read_out, write_out, byte_enable, data_to_sdram
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one pipelined SDRAM master port between the VGA line prefetcher (bursts) and the blitter.
// Optional ARB_BLIT_FAIR_EN: a pending blitter request wins the first IDLE cycle after each burst.
module sdram_port_arbiter #(
    parameter int LINE_WORDS      = 640,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_W          = 25
) (
    input logic                  Clk,
    input logic                  Reset_n,
    sdram_port_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WORDS);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE, VGA_BURST, VGA_DRAIN, BLIT_WRITE, BLIT_READ, BLIT_WAIT
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  returned;
    logic [OUT_W-1:0]  outstanding;
    logic [31:0]       blit_rdata_r;
    logic [31:0]       vga_data_p1;
    logic              vld_p1;
    logic              done_p1;
    logic              fin_p1;

    logic              rd_cmd, wr_cmd;
    logic [ADDR_W-1:0] addr_cmd;
    logic [3:0]        be_cmd;
    logic [31:0]       wdata_cmd;
    logic              start_vga, burst_end, blit_done;
    logic              accept, vga_phase, vga_accept, vga_return;
    logic              blit_wr_req, blit_rd_req, blit_first;

    assign accept     = (rd_cmd | wr_cmd) & ~bus.wait_req;
    assign vga_phase  = (state == VGA_BURST) || (state == VGA_DRAIN);
    assign vga_accept = accept && (state == VGA_BURST);
    assign vga_return = bus.valid && vga_phase;

    // A blitter still holds its request during the finished pulse; it must not be granted twice.
    assign blit_wr_req = bus.blit_write && !fin_p1;
    assign blit_rd_req = bus.blit_read && !fin_p1;

`ifdef ARB_BLIT_FAIR_EN
    logic blit_pri;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            blit_pri <= 1'b0;
        else if (burst_end)
            blit_pri <= 1'b1;
        else if (state == IDLE)
            blit_pri <= 1'b0;
    end

    assign blit_first = blit_pri && (blit_wr_req || blit_rd_req);
`else
    assign blit_first = 1'b0;
`endif

    always_comb begin
        state_next = state;
        rd_cmd     = 1'b0;
        wr_cmd     = 1'b0;
        addr_cmd   = '0;
        be_cmd     = '0;
        wdata_cmd  = '0;
        start_vga  = 1'b0;
        burst_end  = 1'b0;
        blit_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.vga_req && !blit_first) begin
                    start_vga  = 1'b1;
                    state_next = VGA_BURST;
                end else if (blit_wr_req) begin
                    state_next = BLIT_WRITE;
                end else if (blit_rd_req) begin
                    state_next = BLIT_READ;
                end
            end
            VGA_BURST: begin
                rd_cmd   = (outstanding < OUT_MAX);
                addr_cmd = base_r + ADDR_W'(issued);
                be_cmd   = 4'hF;
                if (rd_cmd && !bus.wait_req && (issued == LAST_IDX))
                    state_next = VGA_DRAIN;
            end
            VGA_DRAIN: begin
                if (returned == LINE_CNT) begin
                    burst_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            BLIT_WRITE: begin
                wr_cmd    = 1'b1;
                addr_cmd  = bus.blit_address;
                wdata_cmd = bus.blit_wdata;
                be_cmd    = bus.blit_byteenable;
                if (!bus.wait_req) begin
                    blit_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            BLIT_READ: begin
                rd_cmd   = 1'b1;
                addr_cmd = bus.blit_address;
                be_cmd   = 4'hF;
                if (!bus.wait_req)
                    state_next = BLIT_WAIT;
            end
            BLIT_WAIT: begin
                if (bus.valid) begin
                    blit_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            base_r       <= '0;
            issued       <= '0;
            returned     <= '0;
            outstanding  <= '0;
            done_p1      <= 1'b0;
            fin_p1       <= 1'b0;
            blit_rdata_r <= '0;
        end else begin
            state   <= state_next;
            done_p1 <= burst_end;
            fin_p1  <= blit_done;
            if (start_vga) begin
                base_r      <= bus.vga_base;
                issued      <= '0;
                returned    <= '0;
                outstanding <= '0;
            end else begin
                if (vga_accept)
                    issued <= issued + 1'b1;
                if (vga_return)
                    returned <= returned + 1'b1;
                if (vga_accept && !vga_return)
                    outstanding <= outstanding + 1'b1;
                else if (!vga_accept && vga_return && (outstanding != '0))
                    outstanding <= outstanding - 1'b1;
            end
            if ((state == BLIT_WAIT) && bus.valid)
                blit_rdata_r <= bus.data_from_mem;
        end
    end

    // Stage p0 -> p1: VGA return path, one register between SDRAM and the line FIFO
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1      <= 1'b0;
            vga_data_p1 <= '0;
        end else begin
            vld_p1      <= vga_return;
            vga_data_p1 <= vga_return ? bus.data_from_mem : '0;
        end
    end

    assign bus.vga_busy       = vga_phase;
    assign bus.vga_data       = vga_data_p1;
    assign bus.vga_data_valid = vld_p1;
    assign bus.vga_done       = done_p1;
    assign bus.blit_rdata     = blit_rdata_r;
    assign bus.blit_finished  = fin_p1;
    assign bus.address_out    = addr_cmd;
    assign bus.read_out       = rd_cmd;
    assign bus.write_out      = wr_cmd;
    assign bus.byte_enable    = be_cmd;
    assign bus.data_to_sdram  = wdata_cmd;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: an SDRAM responder with fixed read latency plus
// a negedge monitor that counts commands and returned words against hand-derived expectations.
module tb_sdram_port_arbiter;
    localparam int AW = 25;

    logic Clk = 1'b0;
    logic Reset_n;

    sdram_port_arbiter_if #(.ADDR_W(AW)) bus ();

    sdram_port_arbiter #(
        .LINE_WORDS(640),
        .MAX_OUTSTANDING(8),
        .ADDR_W(AW)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus.master)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_rd, n_vdv, n_done, n_wr, n_brd, n_fin;
    int idx_rd, idx_vd, addr_err, vdata_err, stall_viol, tb_out, max_out;
    int lat = 3;
    bit stall_en = 1'b0;
    bit wrap_seen, prev_stall, prev_rd, prev_wr;
    logic [AW-1:0] cur_base, prev_addr, last_acc, wr_addr, brd_addr;
    logic [31:0]   wr_data, fin_rdata, blit_rsp;
    logic [3:0]    wr_be;
    bit            rsp_v   [16];
    bit            rsp_vga [16];
    logic [31:0]   rsp_d   [16];

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        return {7'h2B, a};
    endfunction

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] b, input int i);
        logic [31:0] s;
        s = 32'(b) + 32'(i);
        return s[AW-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic clear_stats();
        n_rd = 0; n_vdv = 0; n_done = 0; n_wr = 0; n_brd = 0; n_fin = 0;
        idx_rd = 0; idx_vd = 0; addr_err = 0; vdata_err = 0; stall_viol = 0;
        tb_out = 0; max_out = 0; wrap_seen = 1'b0; last_acc = '0;
    endtask

    // SDRAM responder and bus monitor; inputs for the next rising edge are set here
    initial begin
        bit acc;
        bus.valid         = 1'b0;
        bus.data_from_mem = '0;
        bus.wait_req      = 1'b0;
        prev_stall = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0;
        for (int i = 0; i < 16; i++) begin
            rsp_v[i] = 1'b0; rsp_vga[i] = 1'b0; rsp_d[i] = '0;
        end
        forever begin
            @(negedge Clk);
            if (prev_stall && (bus.read_out !== prev_rd || bus.write_out !== prev_wr ||
                               bus.address_out !== prev_addr))
                stall_viol++;
            bus.valid         = rsp_v[0];
            bus.data_from_mem = rsp_d[0];
            if (rsp_v[0] && rsp_vga[0])
                tb_out--;
            for (int i = 0; i < 15; i++) begin
                rsp_v[i] = rsp_v[i+1]; rsp_vga[i] = rsp_vga[i+1]; rsp_d[i] = rsp_d[i+1];
            end
            rsp_v[15] = 1'b0; rsp_vga[15] = 1'b0; rsp_d[15] = '0;
            bus.wait_req = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            acc        = (bus.read_out || bus.write_out) && !bus.wait_req;
            prev_stall = (bus.read_out || bus.write_out) && bus.wait_req;
            prev_rd    = bus.read_out;
            prev_wr    = bus.write_out;
            prev_addr  = bus.address_out;
            if (acc && bus.read_out) begin
                rsp_v[lat-1] = 1'b1;
                if (bus.vga_busy) begin
                    rsp_d[lat-1]   = memf(bus.address_out);
                    rsp_vga[lat-1] = 1'b1;
                    tb_out++;
                    if (tb_out > max_out) max_out = tb_out;
                    if (bus.address_out !== wrap_add(cur_base, idx_rd)) addr_err++;
                    if (bus.address_out == '0 && last_acc == {AW{1'b1}}) wrap_seen = 1'b1;
                    last_acc = bus.address_out;
                    idx_rd++;
                    n_rd++;
                end else begin
                    rsp_d[lat-1]   = blit_rsp;
                    rsp_vga[lat-1] = 1'b0;
                    brd_addr = bus.address_out;
                    n_brd++;
                end
            end
            if (acc && bus.write_out) begin
                n_wr++;
                wr_addr = bus.address_out;
                wr_data = bus.data_to_sdram;
                wr_be   = bus.byte_enable;
            end
            if (bus.vga_data_valid) begin
                if (bus.vga_data !== memf(wrap_add(cur_base, idx_vd))) vdata_err++;
                idx_vd++;
                n_vdv++;
            end
            if (bus.vga_done) begin
                n_done++;
                idx_rd = 0;
                idx_vd = 0;
            end
            if (bus.blit_finished) begin
                n_fin++;
                fin_rdata = bus.blit_rdata;
            end
        end
    end

    task automatic run_burst(input logic [AW-1:0] base, input bit stall, input int lt,
                             input string nm);
        clear_stats();
        cur_base = base;
        lat      = lt;
        stall_en = stall;
        bus.vga_base = base;
        bus.vga_req  = 1'b1;
        tick();
        check_eq({nm, "_busy"}, bus.vga_busy, 1);
        bus.vga_req = 1'b0;
        for (int i = 0; i < 4000 && n_done == 0; i++) tick();
        stall_en = 1'b0;
        repeat (16) tick();
        check_eq({nm, "_reads"}, n_rd, 640);
        check_eq({nm, "_addr_err"}, addr_err, 0);
        check_eq({nm, "_data_valid"}, n_vdv, 640);
        check_eq({nm, "_data_err"}, vdata_err, 0);
        check_eq({nm, "_done"}, n_done, 1);
        check_eq({nm, "_max_out_le8"}, (max_out <= 8), 1);
        check_eq({nm, "_idle"}, bus.vga_busy, 0);
    endtask

    task automatic blit_op(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] be, input string nm);
        int f0;
        f0 = n_fin;
        bus.blit_address    = a;
        bus.blit_wdata      = d;
        bus.blit_byteenable = be;
        if (wr) bus.blit_write = 1'b1;
        else    bus.blit_read  = 1'b1;
        for (int i = 0; i < 50 && n_fin == f0; i++) tick();
        bus.blit_write = 1'b0;
        bus.blit_read  = 1'b0;
        check_eq({nm, "_finished"}, n_fin, f0 + 1);
        repeat (4) tick();
        check_eq({nm, "_single_pulse"}, n_fin, f0 + 1);
    endtask

    initial begin
        int vdv0;
        Reset_n             = 1'b0;
        bus.vga_req         = 1'b0;
        bus.vga_base        = '0;
        bus.blit_read       = 1'b0;
        bus.blit_write      = 1'b0;
        bus.blit_address    = '0;
        bus.blit_wdata      = '0;
        bus.blit_byteenable = '0;
        blit_rsp  = '0;
        cur_base  = '0;
        wr_addr = '0; wr_data = '0; wr_be = '0; brd_addr = '0; fin_rdata = '0;
        clear_stats();
        repeat (3) tick();
        check_eq("rst_cmd", {bus.read_out, bus.write_out, bus.address_out}, 0);
        check_eq("rst_vga", {bus.vga_busy, bus.vga_data_valid, bus.vga_done, bus.vga_data}, 0);
        check_eq("rst_blit", {bus.blit_finished, bus.blit_rdata}, 0);
        Reset_n = 1'b1;
        repeat (2) tick();

        run_burst(25'd1280, 1'b0, 3, "clean");
        run_burst(25'd4096, 1'b1, 12, "stall");
        check_eq("stall_hold", stall_viol, 0);

        clear_stats();
        lat = 3;
        blit_op(1'b1, 25'h100, 32'hDEADBEEF, 4'b0011, "bwr");
        check_eq("bwr_count", n_wr, 1);
        check_eq("bwr_addr", wr_addr, 25'h100);
        check_eq("bwr_data", wr_data, 32'hDEADBEEF);
        check_eq("bwr_be", wr_be, 4'b0011);
        blit_rsp = 32'hDEADBEEF;
        blit_op(1'b0, 25'h100, 32'h0, 4'h0, "brd");
        check_eq("brd_addr", brd_addr, 25'h100);
        check_eq("brd_rdata", fin_rdata, 32'hDEADBEEF);
        check_eq("brd_writes", n_wr, 1);

        // Contention: both requesters raised in the same IDLE cycle, prefetcher keeps asking
        clear_stats();
        cur_base = 25'd2000; lat = 3; blit_rsp = 32'h12345678;
        bus.vga_base = 25'd2000; bus.vga_req = 1'b1;
        bus.blit_address = 25'h2A0; bus.blit_read = 1'b1;
        tick();
        check_eq("cont_vga_first", bus.vga_busy, 1);
        check_eq("cont_no_blit", n_brd, 0);
        for (int i = 0; i < 2000 && n_done == 0; i++) tick();
        check_eq("cont_done1", n_done, 1);
        tick();
`ifdef ARB_BLIT_FAIR_EN
        check_eq("cont_blit_served", n_brd, 1);
        check_eq("cont_vga_held", bus.vga_busy, 0);
        for (int i = 0; i < 50 && n_fin == 0; i++) tick();
        bus.vga_req = 1'b0; bus.blit_read = 1'b0;
`else
        check_eq("cont_blit_waits", n_brd, 0);
        check_eq("cont_vga_again", bus.vga_busy, 1);
        bus.vga_req = 1'b0;
        for (int i = 0; i < 2000 && n_done < 2; i++) tick();
        check_eq("cont_done2", n_done, 2);
        for (int i = 0; i < 50 && n_fin == 0; i++) tick();
        bus.blit_read = 1'b0;
`endif
        repeat (4) tick();
        check_eq("cont_blit_reads", n_brd, 1);
        check_eq("cont_blit_rdata", fin_rdata, 32'h12345678);
        check_eq("cont_addr_err", addr_err, 0);

        run_burst(25'h1FFFF00, 1'b0, 3, "wrap");
        check_eq("wrap_seen", wrap_seen, 1);

        // Reset mid-burst: reset lands before the 101st read reaches a clock edge
        clear_stats();
        cur_base = 25'd5000; lat = 5;
        bus.vga_base = 25'd5000; bus.vga_req = 1'b1;
        tick();
        bus.vga_req = 1'b0;
        for (int i = 0; i < 400 && n_rd < 101; i++) tick();
        check_eq("mid_progress", n_rd, 101);
        check_eq("mid_outstanding", tb_out, 5);
        Reset_n = 1'b0;
        #1;
        check_eq("mid_cmd", {bus.read_out, bus.write_out, bus.address_out}, 0);
        check_eq("mid_vga", {bus.vga_busy, bus.vga_data_valid, bus.vga_data}, 0);
        check_eq("mid_blit_rdata", bus.blit_rdata, 0);
        vdv0 = n_vdv;
        repeat (3) tick();
        Reset_n = 1'b1;
        repeat (10) tick();
        check_eq("mid_no_data", n_vdv, vdv0);
        check_eq("mid_no_done", n_done, 0);
        check_eq("mid_no_reads", n_rd, 101);
        check_eq("mid_idle", bus.vga_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
